// File: rtl/alarm_ctrl.sv
// Alarm controller: arm/ring/snooze state machine driven by 1 Hz ticks and a time-match level.
// Optional snooze support is compiled in with `define ALARM_SNOOZE_EN.
module alarm_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int SNZ_MAX    = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en1hz_i,
    input  logic       sig2hz_i,
    input  logic       match_i,
    input  logic       arm_i,
    input  logic       stop_i,
    input  logic       snooze_i,
    output logic       buzz_o,
    output logic       led_o,
    output logic [1:0] state_o,
    output logic [1:0] snz_o,
    output logic [8:0] remain_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_RING  = 2'b10,
        S_SNZW  = 2'b11
    } state_e;

    localparam logic [8:0] RING_V = 9'(RING_SEC);

`ifdef ALARM_SNOOZE_EN
    localparam logic [8:0] SNOOZE_V  = 9'(SNOOZE_SEC);
    localparam logic [1:0] SNZ_MAX_V = 2'(SNZ_MAX);
`else
    localparam int unused_snooze_p = SNOOZE_SEC + SNZ_MAX;
    logic unused_snooze;
    assign unused_snooze = snooze_i;
`endif

    state_e     state_q, state_d;
    logic [8:0] remain_q, remain_d;
    logic [1:0] snz_q, snz_d;
    logic       match_q;
    logic       buzz_q, buzz_d;
    logic       led_q, led_d;
    logic       match_evt;

    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        snz_d     = snz_q;
        match_evt = match_i & ~match_q;

        case (state_q)
            S_IDLE: begin
                if (arm_i) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (arm_i) begin
                    state_d  = S_IDLE;
                    remain_d = '0;
                    snz_d    = '0;
                end else if (match_evt) begin
                    state_d  = S_RING;
                    remain_d = RING_V;
                    snz_d    = '0;
                end
            end
            S_RING: begin
                if (arm_i) begin
                    state_d  = S_IDLE;
                    remain_d = '0;
                    snz_d    = '0;
                end else if (stop_i) begin
                    state_d  = S_ARMED;
                    remain_d = '0;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze_i && (snz_q < SNZ_MAX_V)) begin
                    state_d  = S_SNZW;
                    remain_d = SNOOZE_V;
                    snz_d    = snz_q + 2'd1;
`endif
                end else if (en1hz_i && (remain_q != '0)) begin
                    // Last tick ends the ring; the counter never decrements past zero.
                    if (remain_q == 9'd1) begin
                        state_d  = S_ARMED;
                        remain_d = '0;
                    end else begin
                        remain_d = remain_q - 9'd1;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            S_SNZW: begin
                if (arm_i) begin
                    state_d  = S_IDLE;
                    remain_d = '0;
                    snz_d    = '0;
                end else if (stop_i) begin
                    state_d  = S_ARMED;
                    remain_d = '0;
                end else if (en1hz_i && (remain_q != '0)) begin
                    if (remain_q == 9'd1) begin
                        state_d  = S_RING;
                        remain_d = RING_V;
                    end else begin
                        remain_d = remain_q - 9'd1;
                    end
                end
            end
`endif
            default: begin
                state_d  = S_IDLE;
                remain_d = '0;
                snz_d    = '0;
            end
        endcase

        buzz_d = (state_d == S_RING) & sig2hz_i;
        case (state_d)
            S_IDLE:  led_d = 1'b0;
            S_SNZW:  led_d = sig2hz_i;
            default: led_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            remain_q <= '0;
            snz_q    <= '0;
            match_q  <= 1'b0;
            buzz_q   <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            snz_q    <= snz_d;
            match_q  <= match_i;
            buzz_q   <= buzz_d;
            led_q    <= led_d;
        end
    end

    assign state_o  = state_q;
    assign remain_o = remain_q;
    assign snz_o    = snz_q;
    assign buzz_o   = buzz_q;
    assign led_o    = led_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with RING_SEC=3, SNOOZE_SEC=5, SNZ_MAX=2.
// Expectations are queued as stimulus is applied and checked after each clock edge.
module tb_alarm_ctrl;

    localparam int RS = 3;
    localparam int SS = 5;
    localparam int SM = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en1hz = 1'b0;
    logic       sig2hz = 1'b0;
    logic       match = 1'b0;
    logic       arm = 1'b0;
    logic       stop = 1'b0;
    logic       snooze = 1'b0;
    logic       buzz;
    logic       led;
    logic [1:0] state;
    logic [1:0] snz;
    logic [8:0] remain;

    always #5 clk = ~clk;

    alarm_ctrl #(.RING_SEC(RS), .SNOOZE_SEC(SS), .SNZ_MAX(SM)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en1hz_i (en1hz),
        .sig2hz_i(sig2hz),
        .match_i (match),
        .arm_i   (arm),
        .stop_i  (stop),
        .snooze_i(snooze),
        .buzz_o  (buzz),
        .led_o   (led),
        .state_o (state),
        .snz_o   (snz),
        .remain_o(remain)
    );

    typedef struct {
        string tag;
        int    st;
        int    sz;
        int    rem;
        int    bz;
        int    ld;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    task automatic push(input string tag, input int st, input int sz, input int rem,
                        input int bz, input int ld);
        exp_t e;
        e.tag = tag; e.st = st; e.sz = sz; e.rem = rem; e.bz = bz; e.ld = ld;
        q.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field, input int obs, input int exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s.%s: observed %0d expected %0d", tag, field, obs, exp_v);
        end
    endtask

    // A field expected as -1 is not checked at that point.
    task automatic check();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.st  >= 0) cmp(e.tag, "state",  int'(state),  e.st);
            if (e.sz  >= 0) cmp(e.tag, "snz",    int'(snz),    e.sz);
            if (e.rem >= 0) cmp(e.tag, "remain", int'(remain), e.rem);
            if (e.bz  >= 0) cmp(e.tag, "buzz",   int'(buzz),   e.bz);
            if (e.ld  >= 0) cmp(e.tag, "led",    int'(led),    e.ld);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock with the currently driven inputs; pulse inputs drop afterwards.
    task automatic cyc(input string tag, input int st, input int sz, input int rem,
                       input int bz, input int ld);
        push(tag, st, sz, rem, bz, ld);
        step();
        arm = 1'b0; stop = 1'b0; snooze = 1'b0; en1hz = 1'b0;
        check();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        push("rst_async", 0, 0, 0, 0, 0);
        check();
        step();
        step();
        rst_n = 1'b1;

        // Arming while match is already high must not ring.
        match = 1'b1; sig2hz = 1'b1;
        cyc("idle_match_ignored", 0, 0, 0, 0, 0);
        arm = 1'b1;
        cyc("arm", 1, 0, 0, 0, -1);
        cyc("armed_match_held", 1, 0, 0, 0, 1);
        match = 1'b0;
        cyc("match_low", 1, 0, 0, 0, 1);
        match = 1'b1;
        cyc("ring_entry", 2, 0, RS, 1, -1);
        sig2hz = 1'b0;
        cyc("buzz_gated_low", 2, 0, RS, 0, 1);
        sig2hz = 1'b1; en1hz = 1'b1;
        cyc("tick1", 2, 0, 2, 1, 1);
        cyc("no_tick", 2, 0, 2, 1, 1);
        en1hz = 1'b1;
        cyc("tick2", 2, 0, 1, 1, 1);
        en1hz = 1'b1;
        cyc("ring_timeout", 1, 0, 0, 0, 1);

        // Stop while match stays high; a fresh rising edge is needed to ring again.
        match = 1'b0;
        cyc("rearm_low", 1, 0, 0, 0, 1);
        match = 1'b1;
        cyc("ring2", 2, 0, RS, 1, 1);
        stop = 1'b1;
        cyc("stop", 1, 0, 0, 0, 1);
        cyc("no_rering_a", 1, 0, 0, 0, 1);
        en1hz = 1'b1;
        cyc("no_rering_b", 1, 0, 0, 0, 1);
        match = 1'b0;
        cyc("match_fall", 1, 0, 0, 0, 1);
        match = 1'b1;
        cyc("ring3", 2, 0, RS, 1, 1);

`ifdef ALARM_SNOOZE_EN
        snooze = 1'b1;
        cyc("snooze1", 3, 1, SS, 0, 1);
        sig2hz = 1'b0;
        cyc("snzw_led_blink", 3, 1, SS, 0, 0);
        sig2hz = 1'b1; snooze = 1'b1;
        cyc("snooze_in_snzw", 3, 1, SS, 0, 1);
        for (int i = SS - 1; i >= 1; i--) begin
            en1hz = 1'b1;
            cyc("snzw_tick", 3, 1, i, 0, 1);
        end
        en1hz = 1'b1;
        cyc("snzw_expire", 2, 1, RS, 1, 1);
        snooze = 1'b1;
        cyc("snooze2", 3, 2, SS, 0, 1);
        for (int i = SS - 1; i >= 1; i--) begin
            en1hz = 1'b1;
            cyc("snzw_tick2", 3, 2, i, 0, 1);
        end
        en1hz = 1'b1;
        cyc("snzw_expire2", 2, 2, RS, 1, 1);
        snooze = 1'b1;
        cyc("snooze3_ignored", 2, 2, RS, 1, 1);
        en1hz = 1'b1;
        cyc("ring_tick_a", 2, 2, 2, 1, 1);
        en1hz = 1'b1;
        cyc("ring_tick_b", 2, 2, 1, 1, 1);
        en1hz = 1'b1;
        cyc("snz_held_timeout", 1, 2, 0, 0, 1);
        match = 1'b0;
        cyc("match_fall2", 1, 2, 0, 0, 1);
        match = 1'b1;
        cyc("ring_snz_cleared", 2, 0, RS, 1, 1);

        arm = 1'b1; stop = 1'b1; snooze = 1'b1;
        cyc("arm_stop_snooze", 0, 0, 0, 0, -1);
        cyc("idle_led_off", 0, 0, 0, 0, 0);
        arm = 1'b1;
        cyc("rearm", 1, 0, 0, 0, -1);
        match = 1'b0;
        cyc("match_fall3", 1, 0, 0, 0, 1);
        match = 1'b1;
        cyc("ring4", 2, 0, RS, 1, 1);
        snooze = 1'b1;
        cyc("snooze_before_rst", 3, 1, SS, 0, 1);
        en1hz = 1'b1;
        cyc("snzw_tick_before_rst", 3, 1, SS - 1, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        push("rst_mid_snzw", 0, 0, 0, 0, 0);
        check();
`else
        snooze = 1'b1;
        cyc("snooze_ignored", 2, 0, RS, 1, 1);
        en1hz = 1'b1;
        cyc("nosnz_tick1", 2, 0, 2, 1, 1);
        en1hz = 1'b1;
        cyc("nosnz_tick2", 2, 0, 1, 1, 1);
        en1hz = 1'b1; snooze = 1'b1;
        cyc("nosnz_timeout", 1, 0, 0, 0, 1);
        match = 1'b0;
        cyc("match_fall2", 1, 0, 0, 0, 1);
        match = 1'b1;
        cyc("ring4", 2, 0, RS, 1, 1);
        en1hz = 1'b1;
        cyc("ring_tick_before_rst", 2, 0, 2, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        push("rst_mid_ring", 0, 0, 0, 0, 0);
        check();
`endif

        // After reset the event is gone and a new match edge must not ring without ARM.
        step();
        rst_n = 1'b1;
        match = 1'b0;
        cyc("post_rst_idle", 0, 0, 0, 0, 0);
        match = 1'b1;
        cyc("post_rst_no_ring", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
